// File: rtl/gray_counter_div.sv
// Gray-code counter stepped by an internal clock-enable prescaler (no derived clocks).
// Supports up/down, sync clear, binary load, freeze, binary readback and a wrap pulse.
module gray_counter_div #(
  parameter int WIDTH = 3,
  parameter int DIV   = 4,
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             step,
  output logic             wrap
);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [DIV_W-1:0] p_q, p_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             tick;
  logic [WIDTH-1:0] nb;

  assign tick = en && (p_q == DIV_W'(DIV - 1));
  assign nb   = up ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));

  // Pulses default low so step/wrap last exactly one cycle.
  always_comb begin
    p_d    = p_q;
    bin_d  = bin_q;
    gray_d = gray_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (clr) begin
      p_d    = '0;
      bin_d  = '0;
      gray_d = '0;
    end else if (load) begin
      p_d    = '0;
      bin_d  = load_bin;
      gray_d = bin2gray(load_bin);
    end else if (tick) begin
      p_d    = '0;
      bin_d  = nb;
      gray_d = bin2gray(nb);
      step_d = 1'b1;
      wrap_d = up ? (&bin_q) : (bin_q == '0);
    end else if (en) begin
      p_d = p_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q    <= '0;
      bin_q  <= '0;
      gray_q <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      bin_q  <= bin_d;
      gray_q <= gray_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign gray = gray_q;
  assign bin  = bin_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule
